// File: rtl/sram_stream_port.sv
// Valid/ready request front end for the single-port sram macro, with a fall-through response FIFO.
// Define SRAM_STREAM_PORT_STATS_EN to build the saturating read/write request counters.
module sram_stream_port #(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_WORDS  = 1024,
  parameter  int RSP_DEPTH  = 2,
  parameter  int CNT_WIDTH  = 32,
  localparam int AW         = $clog2(NUM_WORDS),
  localparam int BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [CNT_WIDTH-1:0]  rd_cnt_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic                  inflight;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic [CW:0]           credit_used;
  logic                  accept;
  logic                  accept_rd;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  // A read holds its credit from acceptance until its data leaves the FIFO or bypasses it.
  assign credit_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
  assign req_ready_o = !rst_i && (credit_used < (CW+1)'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign accept_rd   = accept && !req_we_i;

  assign sram_req_o   = accept;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_we_i ? req_be_i : '0;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(RSP_DEPTH));

  // Reset also hides a read still in flight so its data never reaches the consumer.
  assign rsp_valid_o = !rst_i && (!fifo_empty || inflight);
  assign rsp_rdata_o = fifo_empty ? sram_rdata_i : fifo_mem[rd_ptr];

  assign push = !rst_i && inflight && !(fifo_empty && rsp_ready_i);
  assign pop  = !rst_i && !fifo_empty && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      inflight <= accept_rd;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_rdata_i;
    end
  end

  no_push_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

`ifdef SRAM_STREAM_PORT_STATS_EN
  logic                 accept_wr;
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;

  assign accept_wr = accept && req_we_i;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (accept_rd && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
      end
      if (accept_wr && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_stream_port.sv
// Self-checking bench for sram_stream_port: behavioural sram macro, reference memory and response scoreboard.
module tb_sram_stream_port;

  localparam int DW   = 64;
  localparam int AW   = 10;
  localparam int BW   = 8;
  localparam int CNTW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic [DW-1:0] sram_rdata = '0;
  logic [CNTW-1:0] rd_cnt;
  logic [CNTW-1:0] wr_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;
  bit rand_ready = 1'b0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] sram_mem [1024];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  sram_stream_port #(
    .DATA_WIDTH(DW), .NUM_WORDS(1024), .RSP_DEPTH(2), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural sram macro: byte-masked writes, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
  endtask

  // Scoreboard: pop and compare delivered responses, then record newly accepted requests.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_rd = 0;
      exp_wr = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL rsp_unexpected: got response %h, required none outstanding", rsp_rdata);
        end else begin
          checkOutput("rsp_data", rsp_rdata, exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < BW; b++) begin
            if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
          end
          exp_wr++;
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
          exp_rd++;
        end
      end
    end
  end

  function automatic logic [DW-1:0] preVal(input int i);
    return (64'(i) * 64'h0101_0101_0101_0101) ^ 64'hF0E1_D2C3_B4A5_9687;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance with valid still high.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    bit done = 1'b0;
    int waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
      end else if (++waited > 200) begin
        n_checks++;
        $display("[TB] FAIL accept_timeout: got no acceptance in %0d cycles, required acceptance", waited);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounters(input string tag);
`ifdef SRAM_STREAM_PORT_STATS_EN
    checkOutput({tag, "_rd_cnt"}, 64'(rd_cnt), 64'(exp_rd));
    checkOutput({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
`else
    checkOutput({tag, "_rd_cnt"}, 64'(rd_cnt), 64'd0);
    checkOutput({tag, "_wr_cnt"}, 64'(wr_cnt), 64'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{1'b1, 10'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'h0};
    vecs[1] = '{1'b0, 10'd5, 64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 10'd7, 64'h0, 8'hFF, 64'h0};
    vecs[3] = '{1'b1, 10'd7, 64'h11223344_55667788, 8'h0F, 64'h0};
    vecs[4] = '{1'b0, 10'd7, 64'h0, 8'h00, 64'h00000000_55667788};
    vecs[5] = '{1'b1, 10'd9, 64'h01234567_89ABCDEF, 8'hFF, 64'h0};
    vecs[6] = '{1'b1, 10'd9, 64'hA5A5A5A5_A5A5A5A5, 8'hF0, 64'h0};
    vecs[7] = '{1'b0, 10'd9, 64'h0, 8'h00, 64'hA5A5A5A5_89ABCDEF};
    vecs[8] = '{1'b0, 10'd5, 64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D};

    // Reset with a request pending: nothing may reach the sram.
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_sram_req", 64'(sram_req), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);
    checkCounters("post_reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, AW'(i), preVal(i), 8'hFF);
    req_valid = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      req_valid = 1'b0;
      @(negedge clk);
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d_write_no_rsp", i), 64'(rsp_valid), 64'd0);
      end else begin
        checkOutput($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
        checkOutput($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
        checkOutput($sformatf("vec%0d_fifo_cnt", i), 64'(dut.fifo_cnt), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    checkCounters("table");

    $display("[TB] backpressure sequence");
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd0;
    @(negedge clk);
    checkOutput("bp_accept0", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_addr = 10'd1;
    @(negedge clk);
    checkOutput("bp_accept1", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_addr = 10'd2;
    @(negedge clk);
    checkOutput("bp_stall_c2", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_stall_c3", 64'(req_ready), 64'd0);
    checkOutput("bp_fifo_full", 64'(dut.fifo_cnt), 64'd2);
    checkOutput("bp_head_valid", 64'(rsp_valid), 64'd1);
    checkOutput("bp_head_data", rsp_rdata, preVal(0));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_pop_cycle", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_ready_after_pop", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 10'd3, 64'h0, 8'h00);
    req_valid = 1'b0;
    waitDrain("bp_drain");

    $display("[TB] streaming reads");
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_addr = AW'(i);
      @(negedge clk);
      checkOutput($sformatf("stream_ready%0d", i), 64'(req_ready), 64'd1);
      if (i > 0) checkOutput($sformatf("stream_rsp%0d", i - 1), 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("stream_rsp15", 64'(rsp_valid), 64'd1);
    checkOutput("stream_fifo_cnt", 64'(dut.fifo_cnt), 64'd0);
    @(posedge clk);
    #1;
    waitDrain("stream_drain");

    $display("[TB] random mixed traffic");
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                    {$urandom, $urandom}, BW'($urandom_range(0, 255)));
    end
    req_valid  = 1'b0;
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    waitDrain("random_drain");
    checkCounters("random");

    $display("[TB] reset with a read in flight");
    applyStimulus(1'b0, 10'd5, 64'h0, 8'h00);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_rsp_valid%0d", i), 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("midrst_fifo_cnt", 64'(dut.fifo_cnt), 64'd0);
    checkCounters("midrst");
    applyStimulus(1'b1, 10'd3, 64'h0BAD_F00D_1234_5678, 8'hFF);
    applyStimulus(1'b0, 10'd3, 64'h0, 8'h00);
    req_valid = 1'b0;
    waitDrain("midrst_drain");
    checkCounters("midrst_after");

    $display("[TB] accepted %0d reads and %0d writes since last reset", exp_rd, exp_wr);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_stream_port.md
# sram_stream_port

Request/response front end for the single-port `sram` macro wrapper. It converts a valid/ready request stream into the macro's `req/we/addr/wdata/be` strobes. It captures the 1-cycle-latency read data into a small response FIFO with fall-through, so read data is never lost under downstream backpressure. It sits directly upstream of `sram` and is the only block driving its pins.

## Interface
Parameters:
- `DATA_WIDTH`, 64: data word width; must equal the attached `sram` `DATA_WIDTH`.
- `NUM_WORDS`, 1024: SRAM depth; `AW = $clog2(NUM_WORDS)`.
- `RSP_DEPTH`, 2: response FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  1  upstream request valid.
- `req_ready_o`  out  1  upstream request ready.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  AW  word address.
- `req_wdata_i`  in  DATA_WIDTH  write data.
- `req_be_i`  in  (DATA_WIDTH+7)/8  byte enables (writes only).
- `rsp_valid_o`  out  1  read response valid.
- `rsp_ready_i`  in  1  downstream accepts response.
- `rsp_rdata_o`  out  DATA_WIDTH  read data.
- `sram_req_o`, `sram_we_o`, `sram_addr_o`, `sram_wdata_o`, `sram_be_o`  out  to the `sram` ports of the same names.
- `sram_rdata_i`  in  DATA_WIDTH  from `sram` `rdata_o`; valid exactly 1 cycle after a read strobe.
- `rd_cnt_o`, `wr_cnt_o`  out  CNT_WIDTH  accepted read and write counts.

## Operation
- Handshake: a request transfers on the cycle where `req_valid_i & req_ready_o` is high. Upstream holds `valid` and the request fields stable until the transfer.
- `req_ready_o = !rst_i & (inflight + fifo_cnt < RSP_DEPTH)`.
  - `inflight` is a 1-bit register that is set on the cycle after an accepted read.
  - `req_ready_o` does not depend on `rsp_ready_i` or `req_we_i`. There is no combinational path from the response side.
- SRAM strobes:
  - `sram_req_o = req_valid_i & req_ready_o`.
  - `sram_we_o = req_we_i`.
  - addr, wdata and be are passed through combinationally. When `sram_we_o` is 0, `sram_be_o` is forced to 0.
- Writes produce no response. They consume no FIFO credit but are still gated by `req_ready_o`.
- Response path, in the cycle where `inflight` = 1 (`sram_rdata_i` valid):
  - FIFO empty and `rsp_ready_i` = 1: bypass. The data goes straight to `rsp_rdata_o` and is not stored.
  - Otherwise: the data is pushed into the FIFO tail.
- Output select:
  - `rsp_valid_o = (fifo_cnt != 0) | inflight`.
  - `rsp_rdata_o` = FIFO head if the FIFO is non-empty, else `sram_rdata_i`.
- Pop: when `rsp_valid_o & rsp_ready_i` and the FIFO is non-empty, the head is popped. A push and a pop in the same cycle both take effect, so the count is unchanged and the pointers advance.
- Ordering: responses are returned strictly in request order.
- Credit accounting: it is impossible for a push to find the FIFO full. An implementation assertion checks this.
- Pointers are `$clog2(RSP_DEPTH)` bits wide and wrap naturally. `fifo_cnt` is `$clog2(RSP_DEPTH)+1` bits wide.

## Timing
- Read latency: request accepted in cycle N gives `rsp_valid_o` in cycle N+1 if the FIFO is empty. Otherwise the response is presented after all older entries have drained.
- Throughput: with `rsp_ready_i` held high, one read per cycle is sustained (`inflight` + bypass, `fifo_cnt` = 0).
- Backpressure: with `rsp_ready_i` low, at most `RSP_DEPTH` reads are accepted, then `req_ready_o` drops. Once the FIFO drains, `req_ready_o` rises again one cycle after the pop that frees the credit.
- Reset, while `rst_i` is high:
  - `req_ready_o` = 0 and `sram_req_o` = 0.
  - On the next edge, `inflight`, the pointers, `fifo_cnt` and both counters are cleared.
  - After release: `rsp_valid_o` = 0, `req_ready_o` = 1.
  - A read in flight when reset is asserted is discarded, and its data never appears.

## Configuration
- `SRAM_STREAM_PORT_STATS_EN` defined:
  - `rd_cnt_o` increments on each accepted read.
  - `wr_cnt_o` increments on each accepted write.
  - Both saturate at all-ones and are cleared by `rst_i`.
- Not defined: the counter registers are not instantiated, and `rd_cnt_o` and `wr_cnt_o` are tied to 0.
- All other behaviour is identical with and without the macro.

## Test plan
- Write then read: write 0xDEADBEEF_CAFEF00D to addr 5 with `be` = 0xFF, then read addr 5 with `rsp_ready_i` = 1 → `rsp_valid_o` is high 1 cycle after acceptance with that data, and `fifo_cnt` stays 0.
- Partial write: preload addr 7 = 0, write 0x11223344_55667788 with `be` = 0x0F, then read addr 7 → 0x00000000_55667788.
- Backpressure: `rsp_ready_i` = 0, issue reads to addrs 0..3 back-to-back with `RSP_DEPTH` = 2 → only 2 are accepted and `req_ready_o` is 0 from the third cycle. Then raise `rsp_ready_i` → data for addr 0 and addr 1 arrives in order, and the remaining reads complete.
- Streaming: 16 back-to-back reads with `rsp_ready_i` = 1 → 16 responses on 16 consecutive cycles, and `req_ready_o` never drops.
- Random `rsp_ready_i` toggling over 1000 mixed requests → responses match a reference memory model in order, with no drops and no duplicates.
- Reset mid-operation: assert `rst_i` for 1 cycle in the cycle after a read is accepted → no response appears and `rsp_valid_o` = 0. With `SRAM_STREAM_PORT_STATS_EN` defined, the counters read 0 after reset and then count 1 per accepted request.
